// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM states and constants for the multiply/divide unit
package md_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [31:0] MD_OVF_QUOT = 32'h8000_0000;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU plus a divide-by-zero flag
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);
  logic [63:0] s_prod, u_prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, s_quot, s_rem;
  logic        ovf;
  assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign u_prod = {32'd0, a} * {32'd0, b};
  // signed divide on magnitudes so quotient truncates toward zero and remainder follows the dividend
  assign a_mag  = a[31] ? -a : a;
  assign b_mag  = b[31] ? -b : b;
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign ovf    = a == MD_OVF_QUOT && b == 32'hFFFF_FFFF;
  assign s_quot = ovf ? MD_OVF_QUOT : (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign s_rem  = ovf ? 32'd0 : a[31] ? -r_mag : r_mag;
  assign div_zero = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
  always_comb begin
    result = 64'd0;
    result = op == MD_MULT  ? s_prod :
             op == MD_MULTU ? u_prod :
             op == MD_DIV   ? {s_rem, s_quot} :
             op == MD_DIVU  ? {a % b, a / b} : 64'd0;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers; MD_ABORT_EN adds an abort input
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state;
  logic [31:0] cnt;
  logic [63:0] shadow, result;
  logic        commit, div_zero, kill;
`ifdef MD_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  md_calc u_calc (.op(op), .a(a), .b(b), .result(result), .div_zero(div_zero));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      shadow <= 64'd0;
      commit <= 1'b0;
    end else if (state == IDLE) begin
      if (start && op <= MD_DIVU) begin
        shadow <= result;
        commit <= !div_zero;
        cnt    <= op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
        state  <= RUN;
        busy   <= 1'b1;
      end else if (start && op == MD_MTHI) hi <= a;
      else if (start && op == MD_MTLO) lo <= a;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 32'd0;
    end else begin
      cnt <= cnt - 32'd1;
      if (cnt == 32'd1) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (commit) {hi, lo} <= shadow;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (abort scenario built when MD_ABORT_EN is defined)
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;
`ifdef MD_ABORT_EN
  logic        abort = 1'b0;
`endif
  int checks = 0, errors = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MD_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the first negedge with busy low, n = busy cycles seen
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult got %h_%h want ffffffff_fffffffa", hi, lo); end
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu got %h_%h want 00000001_fffffffe", hi, lo); end
  endtask

  task automatic test_div();
    int n;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div got %h_%h want ffffffff_fffffffd", hi, lo); end
    issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if ({hi, lo} !== 64'h0000_0001_7FFF_FFFC) begin errors++; $display("FAIL divu got %h_%h want 00000001_7ffffffc", hi, lo); end
  endtask

  task automatic test_mthi_divzero();
    int n;
    start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h busy=%0b want 12345678 0", hi, busy); end
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({hi, lo} !== 64'h1234_5678_7FFF_FFFC || busy !== 1'b0) begin errors++; $display("FAIL reserved_op got %h_%h busy=%0b want 12345678_7ffffffc 0", hi, lo, busy); end
    issue(MD_DIV, 32'd99, 32'd0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divzero_busy_cycles got %0d want 10", n); end
    checks++; if ({hi, lo} !== 64'h1234_5678_7FFF_FFFC) begin errors++; $display("FAIL divzero got %h_%h want 12345678_7ffffffc", hi, lo); end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_ignore();
    int low = 0;
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy) low++;
      start = (i == 2) || (i == 4) || (i == 10);
      op = i == 2 ? MD_MTLO : i == 4 ? MD_MULT : MD_MTHI;
      a = i == 2 ? 32'h0000_AAAA : i == 4 ? 32'd3 : 32'h0000_5555;
      b = 32'd3;
    end
    @(negedge clk);
    checks++; if (low !== 0) begin errors++; $display("FAIL ignore_busy_gaps got %0d want 0", low); end
    checks++; if ({busy, hi, lo} !== {1'b0, 64'h0000_0002_0000_000E}) begin errors++; $display("FAIL ignore got busy=%0b %h_%h want 0 00000002_0000000e", busy, hi, lo); end
    start = 1'b1; op = MD_MTLO; a = 32'h0000_7777;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h0000_7777) begin errors++; $display("FAIL start_after_busy got lo=%h want 00007777", lo); end
  endtask

  task automatic test_reset_midop();
    start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("FAIL reset_midop got busy=%0b %h_%h want 0 0_0", busy, hi, lo); end
    repeat (6) @(negedge clk);
    checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("FAIL reset_discard got busy=%0b %h_%h want 0 0_0", busy, hi, lo); end
  endtask

`ifdef MD_ABORT_EN
  task automatic test_abort();
    start = 1'b1; op = MD_MTHI; a = 32'h11;
    @(negedge clk);
    op = MD_MTLO; a = 32'h22;
    @(negedge clk);
    op = MD_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({busy, hi, lo} !== {1'b0, 64'h0000_0011_0000_0022}) begin errors++; $display("FAIL abort got busy=%0b %h_%h want 0 00000011_00000022", busy, hi, lo); end
    repeat (6) @(negedge clk);
    checks++; if ({hi, lo} !== 64'h0000_0011_0000_0022) begin errors++; $display("FAIL abort_discard got %h_%h want 00000011_00000022", hi, lo); end
    abort = 1'b1; start = 1'b1; op = MD_MTHI; a = 32'h33;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++; if (hi !== 32'h33) begin errors++; $display("FAIL abort_idle got hi=%h want 00000033", hi); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_divzero();
    test_ignore();
    test_reset_midop();
`ifdef MD_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
